delay_elem: RTL and testbench
=============================

# delay_elem

Measures the propagation delay of a pulse as a whole number of clock periods. A rising edge on `sent_signal` starts a measurement and a rising edge on `recieved_signal` ends it. The block combines three functions: start/stop gating (blocker), a saturating period counter (counter_15) and a result hold register (buffer). It sits between the wireless sender pulse path and the readout logic, and holds the last measured delay until the next measurement completes.

## Interface
- `PERIODS_DIM`, default 16: width of the counter and of the result, in bits (minimum 2).
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `sent_signal`  in  1: outgoing pulse; its rising edge starts a measurement.
- `recieved_signal`  in  1: returning pulse; its rising edge stops a measurement.
- `delay_in_clk_periods`  out  PERIODS_DIM: last measured delay, in clk periods.
- `busy`  out  1: high while a measurement is in progress (counter enable).
- `done`  out  1: one-cycle pulse when `delay_in_clk_periods` is updated.
- `overflow`  out  1: high when the last result saturated; cleared by the next normal result.

## Operation
- Edge detect: each input has a history register. `edge = s & ~hist`, where `s` is the input after the optional synchronizer. The detection cycle is the cycle in which `edge` is 1.
- FSM states: IDLE and MEAS. `busy = (state == MEAS)`.
- IDLE with a sent edge: go to MEAS and set `cnt <= 1`.
- IDLE with a received edge only: ignored.
- IDLE with both edges in the same cycle: the sent edge wins and the received edge is ignored.
- MEAS with a received edge:
  - `delay_in_clk_periods <= cnt`, `overflow <= 0`, `done <= 1`.
  - Go to IDLE and set `cnt <= 0`.
- MEAS with a sent edge: ignored; no restart.
- MEAS with no received edge and `cnt < 2^PERIODS_DIM-1`: `cnt <= cnt + 1`.
- MEAS with no received edge and `cnt == 2^PERIODS_DIM-1` (timeout):
  - `delay_in_clk_periods <= all-ones`, `overflow <= 1`, `done <= 1`.
  - Go to IDLE and set `cnt <= 0`.
- Counter arithmetic is unsigned and never wraps.
- Result: the reported value equals the detection cycle of the received edge minus the detection cycle of the sent edge. A received edge in the cycle right after the sent edge gives 1. The minimum nonzero result is 1.
- `delay_in_clk_periods` and `overflow` hold their values until the next `done`.

## Timing
- Reset values:
  - state IDLE, `cnt` 0, `busy` 0.
  - `delay_in_clk_periods` 0, `done` 0, `overflow` 0.
  - Edge history registers reset to 1, so an input already high at reset release produces no edge.
- `done`, the result and `overflow` are registered. They become visible in the cycle after the detection cycle of the stop (or timeout).
- `busy` rises in the cycle after the sent detection cycle and falls together with `done`.
- Reset asserted mid-measurement aborts it immediately: all outputs go to their reset values, and no `done` is produced.
- An input pulse must be high for at least one clk period to be detected.

## Configuration
- `DELAY_ELEM_SYNC_EN` defined:
  - Each input passes through a 2-flop synchronizer before edge detect; synchronizer flops reset to 1.
  - Detection occurs 2 cycles later than without the macro, for both inputs.
  - The measured value is unchanged.
- Not defined: inputs are assumed synchronous to `clk` and feed edge detect directly.

## Test plan
- PERIODS_DIM=16: sent rises before edge 10, received rises before edge 400 -> `done` pulses once, `delay_in_clk_periods`=390, `overflow`=0, `busy` high for 390 cycles.
- Received pulse alone in IDLE (result previously 390) -> no `done`, result stays 390, `busy` stays 0.
- Sent edge at cycle 0, second sent edge at cycle 20, received edge at cycle 50 -> result 50 (no restart).
- Sent and received edges in the same cycle, then received again 5 cycles later -> result 5.
- PERIODS_DIM=4, sent edge, no received edge -> after 15 cycles `done`=1, result 15, `overflow`=1. A following sent edge with received 3 cycles later gives result 3 and `overflow`=0.
- `rst` pulsed at cycle 100 of a measurement -> outputs return to 0 at once. No `done`, and a later received edge is ignored. Run all scenarios with and without `DELAY_ELEM_SYNC_EN`; results must be identical.

Source files
------------

// File: rtl/delay_elem.sv
// Pulse propagation delay meter: counts clk periods from a sent rising edge to a received rising edge.
// Optional input synchronizers are enabled by defining DELAY_ELEM_SYNC_EN (adds 2 cycles to both detections).
// Result, done and overflow are registered; the result holds until the next completed measurement.
module delay_elem #(
  parameter int PERIODS_DIM = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sent_signal,
  input  logic                   recieved_signal,
  output logic [PERIODS_DIM-1:0] delay_in_clk_periods,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow
);

  localparam logic [PERIODS_DIM-1:0] CNT_ONE = {{(PERIODS_DIM-1){1'b0}}, 1'b1};
  localparam logic [PERIODS_DIM-1:0] CNT_MAX = {PERIODS_DIM{1'b1}};

  typedef enum logic {IDLE, MEAS} state_t;

  logic sent_s;
  logic rcv_s;

`ifdef DELAY_ELEM_SYNC_EN
  logic [1:0] sent_sync;
  logic [1:0] rcv_sync;

  // Two-flop synchronizers; reset high so a line already high at reset release is not an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sent_sync <= 2'b11;
      rcv_sync  <= 2'b11;
    end else begin
      sent_sync <= {sent_sync[0], sent_signal};
      rcv_sync  <= {rcv_sync[0], recieved_signal};
    end
  end

  assign sent_s = sent_sync[1];
  assign rcv_s  = rcv_sync[1];
`else
  assign sent_s = sent_signal;
  assign rcv_s  = recieved_signal;
`endif

  logic sent_hist;
  logic rcv_hist;
  logic sent_edge;
  logic rcv_edge;

  // Edge history registers; reset to 1 to suppress a false edge on lines high at reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sent_hist <= 1'b1;
      rcv_hist  <= 1'b1;
    end else begin
      sent_hist <= sent_s;
      rcv_hist  <= rcv_s;
    end
  end

  assign sent_edge = sent_s & ~sent_hist;
  assign rcv_edge  = rcv_s & ~rcv_hist;

  state_t                 state_q, state_d;
  logic [PERIODS_DIM-1:0] cnt_q, cnt_d;
  logic [PERIODS_DIM-1:0] delay_q, delay_d;
  logic                   done_q, done_d;
  logic                   ovf_q, ovf_d;

  // State, counter and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      delay_q <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      delay_q <= delay_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state logic: a sent edge arms the counter with 1 so the result equals the detection-cycle
  // difference; a received edge or counter saturation closes the measurement.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    delay_d = delay_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        // Sent wins over a simultaneous received edge; a lone received edge is ignored.
        if (sent_edge) begin
          state_d = MEAS;
          cnt_d   = CNT_ONE;
        end
      end
      MEAS: begin
        // Further sent edges are ignored: no restart while measuring.
        if (rcv_edge) begin
          delay_d = cnt_q;
          ovf_d   = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          delay_d = CNT_MAX;
          ovf_d   = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy                 = (state_q == MEAS);
  assign done                 = done_q;
  assign overflow             = ovf_q;
  assign delay_in_clk_periods = delay_q;

endmodule

// File: tb/tb_delay_elem.sv
module tb_delay_elem;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sent = 1'b0, rcv = 1'b0;
  logic        sent4 = 1'b0, rcv4 = 1'b0;
  logic [15:0] delay16;
  logic [3:0]  delay4;
  logic        busy16, done16, ovf16;
  logic        busy4, done4, ovf4;

  always #5 clk = ~clk;

  delay_elem #(.PERIODS_DIM(16)) dut16 (
    .clk(clk), .rst(rst), .sent_signal(sent), .recieved_signal(rcv),
    .delay_in_clk_periods(delay16), .busy(busy16), .done(done16), .overflow(ovf16)
  );

  delay_elem #(.PERIODS_DIM(4)) dut4 (
    .clk(clk), .rst(rst), .sent_signal(sent4), .recieved_signal(rcv4),
    .delay_in_clk_periods(delay4), .busy(busy4), .done(done4), .overflow(ovf4)
  );

  typedef struct {
    int   delay;
    logic ovf;
  } exp_t;

  typedef struct {
    int   rcv_at;     // cycle (relative to sent rise) at which received rises
    int   sent2_at;   // second sent pulse start, 0 = none
    int   exp_delay;
    logic exp_ovf;
  } vec_t;

  exp_t q16[$];
  exp_t q4[$];
  exp_t e16, e4;
  int   busy_run16 = 0;
  int   busy_run4 = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain16();
    for (int i = 0; i < 40 && q16.size() != 0; i++) step();
    check("drain16_pending", q16.size(), 0);
  endtask

  task automatic drain4();
    for (int i = 0; i < 40 && q4.size() != 0; i++) step();
    check("drain4_pending", q4.size(), 0);
  endtask

  // Scoreboard for the 16-bit instance: every done pops one expectation; busy duration must match.
  always @(negedge clk) begin
    if (rst) begin
      busy_run16 = 0;
    end else begin
      if (done16) begin
        if (q16.size() == 0) begin
          check("unexpected_done16", 1, 0);
        end else begin
          e16 = q16.pop_front();
          check("delay16", int'(delay16), e16.delay);
          check("ovf16", int'(ovf16), int'(e16.ovf));
          check("busy_len16", busy_run16, e16.delay);
        end
        busy_run16 = 0;
      end
      if (busy16) busy_run16++;
    end
  end

  // Scoreboard for the 4-bit instance.
  always @(negedge clk) begin
    if (rst) begin
      busy_run4 = 0;
    end else begin
      if (done4) begin
        if (q4.size() == 0) begin
          check("unexpected_done4", 1, 0);
        end else begin
          e4 = q4.pop_front();
          check("delay4", int'(delay4), e4.delay);
          check("ovf4", int'(ovf4), int'(e4.ovf));
          check("busy_len4", busy_run4, e4.delay);
        end
        busy_run4 = 0;
      end
      if (busy4) busy_run4++;
    end
  end

  vec_t vecs[5];

  initial begin
    vecs[0] = '{rcv_at: 1,   sent2_at: 0,  exp_delay: 1,   exp_ovf: 1'b0};
    vecs[1] = '{rcv_at: 2,   sent2_at: 0,  exp_delay: 2,   exp_ovf: 1'b0};
    vecs[2] = '{rcv_at: 7,   sent2_at: 0,  exp_delay: 7,   exp_ovf: 1'b0};
    vecs[3] = '{rcv_at: 50,  sent2_at: 20, exp_delay: 50,  exp_ovf: 1'b0};
    vecs[4] = '{rcv_at: 390, sent2_at: 0,  exp_delay: 390, exp_ovf: 1'b0};

    // Reset state
    #2;
    check("rst_delay16", int'(delay16), 0);
    check("rst_busy16", int'(busy16), 0);
    check("rst_done16", int'(done16), 0);
    check("rst_ovf16", int'(ovf16), 0);
    check("rst_delay4", int'(delay4), 0);
    check("rst_busy4", int'(busy4), 0);
    repeat (3) step();
    rst = 1'b0;
    repeat (4) step();

    // Table-driven measurements on the 16-bit instance
    for (int v = 0; v < 5; v++) begin
      q16.push_back('{delay: vecs[v].exp_delay, ovf: vecs[v].exp_ovf});
      for (int c = 0; c <= vecs[v].rcv_at + 2; c++) begin
        sent = (c < 2) ||
               (vecs[v].sent2_at > 0 && c >= vecs[v].sent2_at && c < vecs[v].sent2_at + 2);
        rcv  = (c >= vecs[v].rcv_at && c < vecs[v].rcv_at + 2);
        step();
      end
      sent = 1'b0;
      rcv  = 1'b0;
      drain16();
      repeat (4) step();
    end

    // Received pulse alone in IDLE: no done, result holds 390, busy stays low
    rcv = 1'b1;
    step();
    step();
    rcv = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("idle_rcv_busy", int'(busy16), 0);
      step();
    end
    check("idle_rcv_hold", int'(delay16), 390);

    // Sent and received rise together, received again 5 cycles later -> 5
    q16.push_back('{delay: 5, ovf: 1'b0});
    sent = 1'b1; rcv = 1'b1;
    step(); step();
    sent = 1'b0; rcv = 1'b0;
    step(); step(); step();
    rcv = 1'b1;
    step(); step();
    rcv = 1'b0;
    drain16();
    repeat (4) step();

    // 4-bit instance: timeout saturates at 15 with overflow
    q4.push_back('{delay: 15, ovf: 1'b1});
    sent4 = 1'b1;
    step(); step();
    sent4 = 1'b0;
    drain4();
    check("ovf4_hold", int'(ovf4), 1);
    repeat (4) step();

    // Following normal measurement clears overflow
    q4.push_back('{delay: 3, ovf: 1'b0});
    sent4 = 1'b1;
    step(); step(); step();
    rcv4 = 1'b1; sent4 = 1'b0;
    step(); step();
    rcv4 = 1'b0;
    drain4();
    repeat (4) step();

    // Reset in the middle of a measurement aborts it with no done
    sent = 1'b1;
    step(); step();
    sent = 1'b0;
    repeat (100) step();
    check("pre_rst_busy16", int'(busy16), 1);
    rst = 1'b1;
    #1;
    check("abort_delay16", int'(delay16), 0);
    check("abort_busy16", int'(busy16), 0);
    check("abort_done16", int'(done16), 0);
    check("abort_ovf16", int'(ovf16), 0);
    step();
    rst = 1'b0;
    step(); step();
    rcv = 1'b1;
    step(); step();
    rcv = 1'b0;
    repeat (20) step();
    check("post_abort_delay16", int'(delay16), 0);
    check("post_abort_busy16", int'(busy16), 0);
    check("post_abort_queue", q16.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
